// File: rtl/beep_pkg.sv
// Shared definitions for the multi-key beeper: mode encoding, FSM states
// and default timing derived from the board clock.
package beep_pkg;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_TOGGLE  = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_TONE
    } state_t;

    localparam int CLK_FREQ_HZ = 50_000_000;

    function automatic int ms_to_cyc(input int ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_CYC_DEF   = ms_to_cyc(20);
    localparam int BEEP_CYC_DEF       = ms_to_cyc(100);
    // 1 kHz tone for key 0 at the default clock
    localparam int TONE_HALF_BASE_DEF = 25_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, stability counter and a
// one-cycle flag on each accepted press (falling debounced level).
module key_debounce_ch #(
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key,
    output logic key_value,
    output logic key_flag
);
    localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic          sync1_reg;
    logic          sync2_reg;
    logic [DW-1:0] cnt_reg;
    logic          key_value_reg;
    logic          key_flag_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_reg     <= 1'b1;
            sync2_reg     <= 1'b1;
            cnt_reg       <= '0;
            key_value_reg <= 1'b1;
            key_flag_reg  <= 1'b0;
        end else begin
            sync1_reg    <= key;
            sync2_reg    <= sync1_reg;
            key_flag_reg <= 1'b0;
            // Any cycle agreeing with the accepted level restarts the count
            if (sync2_reg == key_value_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DW'(DEBOUNCE_CYC - 1)) begin
                cnt_reg       <= '0;
                key_value_reg <= sync2_reg;
                key_flag_reg  <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign key_value = key_value_reg;
    assign key_flag  = key_flag_reg;

endmodule

// File: rtl/multi_key_beep.sv
// N-key debounce front end feeding a per-key square-wave tone generator,
// played as a fixed burst or as a toggled continuous tone.
module multi_key_beep
    import beep_pkg::*;
#(
    parameter int  NUM_KEYS       = 4,
    parameter int  DEBOUNCE_CYC   = DEBOUNCE_CYC_DEF,
    parameter int  BEEP_CYC       = BEEP_CYC_DEF,
    parameter int  TONE_HALF_BASE = TONE_HALF_BASE_DEF,
    localparam int AW             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key,
    input  logic                mode,
    output logic [NUM_KEYS-1:0] key_value,
    output logic [NUM_KEYS-1:0] key_flag,
    output logic [AW-1:0]       active_key,
    output logic                busy,
    output logic                beep
);
    localparam int BW = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam int TW = (TONE_HALF_BASE * NUM_KEYS > 1) ? $clog2(TONE_HALF_BASE * NUM_KEYS) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
            key_debounce_ch #(
                .DEBOUNCE_CYC(DEBOUNCE_CYC)
            ) u_ch (
                .sys_clk  (sys_clk),
                .sys_rst  (sys_rst),
                .key      (key[gi]),
                .key_value(key_value[gi]),
                .key_flag (key_flag[gi])
            );
        end
    endgenerate

    logic          press_valid;
    logic [AW-1:0] press_idx;

    // Descending scan so the lowest pressed index is the one left standing
    always_comb begin
        press_valid = 1'b0;
        press_idx   = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (key_flag[i]) begin
                press_valid = 1'b1;
                press_idx   = AW'(i);
            end
        end
    end

    state_t        state_reg;
    logic [AW-1:0] active_key_reg;
    logic          mode_reg;
    logic [BW-1:0] burst_cnt_reg;
    logic [TW-1:0] tone_cnt_reg;
    logic          beep_reg;
    logic [TW-1:0] half_m1;

    assign half_m1 = TW'(TONE_HALF_BASE * (int'(active_key_reg) + 1) - 1);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg      <= ST_IDLE;
            active_key_reg <= '0;
            mode_reg       <= MODE_ONESHOT;
            burst_cnt_reg  <= '0;
            tone_cnt_reg   <= '0;
            beep_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    burst_cnt_reg <= '0;
                    tone_cnt_reg  <= '0;
                    beep_reg      <= 1'b0;
                    if (press_valid) begin
                        state_reg      <= ST_TONE;
                        active_key_reg <= press_idx;
                        mode_reg       <= mode;
                    end
                end
                ST_TONE: begin
                    if (press_valid && press_idx == active_key_reg && mode_reg == MODE_TOGGLE) begin
                        state_reg     <= ST_IDLE;
                        burst_cnt_reg <= '0;
                        tone_cnt_reg  <= '0;
                        beep_reg      <= 1'b0;
                    end else if (press_valid) begin
                        // New key, or same key in a burst: restart the tone
                        active_key_reg <= press_idx;
                        mode_reg       <= mode;
                        burst_cnt_reg  <= '0;
                        tone_cnt_reg   <= '0;
                        beep_reg       <= 1'b0;
                    end else if (mode_reg == MODE_ONESHOT && burst_cnt_reg == BW'(BEEP_CYC - 1)) begin
                        state_reg     <= ST_IDLE;
                        burst_cnt_reg <= '0;
                        tone_cnt_reg  <= '0;
                        beep_reg      <= 1'b0;
                    end else begin
                        if (mode_reg == MODE_ONESHOT) begin
                            burst_cnt_reg <= burst_cnt_reg + 1'b1;
                        end
                        if (tone_cnt_reg == half_m1) begin
                            tone_cnt_reg <= '0;
                            beep_reg     <= ~beep_reg;
                        end else begin
                            tone_cnt_reg <= tone_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign active_key = active_key_reg;
    assign busy       = (state_reg == ST_TONE);
    assign beep       = beep_reg;

endmodule

// File: doc/multi_key_beep.md
# multi_key_beep

Parametrised N-key debounce and tone generator for board-level user feedback. Each active-low key input is synchronised and debounced; a debounced press selects a per-key square-wave tone on `beep`, played either as a fixed-length burst or as a toggled continuous tone. It sits between raw board keys and the buzzer pin. It replaces the single-key debounce/beep pair in new designs.

## Interface
- `NUM_KEYS`, 4: number of key channels, range 1..16.
- `DEBOUNCE_CYC`, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz).
- `BEEP_CYC`, 5_000_000: burst length in one-shot mode, in cycles.
- `TONE_HALF_BASE`, 25_000: half-period in cycles for key 0. Key i uses half-period `TONE_HALF_BASE*(i+1)`.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst` in 1: reset. Synchronous, active-high.
- `key` in NUM_KEYS: raw keys, active-low (0 = pressed), asynchronous.
- `mode` in 1: 0 = ONESHOT (burst), 1 = TOGGLE (continuous until re-pressed).
- `key_value` out NUM_KEYS: debounced key levels, active-low.
- `key_flag` out NUM_KEYS: one-cycle pulse per key on each debounced press (1→0 edge only).
- `active_key` out $clog2(NUM_KEYS) (minimum 1): index of the key currently sounding.
- `busy` out 1: high while a tone is playing.
- `beep` out 1: square-wave buzzer drive.

## Operation
- Per channel:
  - Two-flop synchroniser.
  - Counter increments while the synchronised value differs from `key_value[i]`.
  - Any cycle where the values match clears the counter, so bounce restarts the count.
  - When the count reaches `DEBOUNCE_CYC-1`, `key_value[i]` takes the new level and the counter clears.
  - If the new level is 0, `key_flag[i]` pulses for exactly one cycle. Releases update `key_value` but never flag.
- Press selection: when several `key_flag` bits are high in the same cycle, the lowest index wins. The others are ignored.
- FSM states IDLE and TONE:
  - IDLE + press k → TONE, with `active_key`=k and `mode` latched. The latched mode governs the whole tone.
  - TONE (ONESHOT) + burst counter reaches `BEEP_CYC-1` → IDLE.
  - TONE + press of a different key → stay in TONE, switch to the new key, re-latch `mode`, restart the burst and tone counters, set `beep`=0.
  - TONE (TOGGLE) + press of the same key → IDLE.
  - TONE (ONESHOT) + press of the same key → restart the burst.
  - Expiry and a press in the same cycle: the press wins.
- Tone generation:
  - On every entry to TONE or restart, the half-period counter clears and `beep`=0.
  - `beep` inverts every `TONE_HALF_BASE*(active_key+1)` cycles.
  - In IDLE, `beep`=0 and all counters are held at 0.
- A change on `mode` mid-tone has no effect until the next press.

## Timing
- Reset values: `key_value`=all 1s, synchroniser flops=1, `key_flag`=0, `active_key`=0, `busy`=0, `beep`=0, state IDLE, all counters 0.
- Key edge to `key_flag`: 2 synchroniser cycles plus `DEBOUNCE_CYC` stable cycles.
- `key_flag` high in cycle N:
  - `busy`, `active_key` and the new state are valid in N+1.
  - First `beep` rise occurs in N+1+H, where H is the half-period.
- ONESHOT burst: `busy` is high for exactly `BEEP_CYC` cycles, then low. `beep` is forced to 0 in the same cycle `busy` falls.
- Width rules:
  - Debounce counter: $clog2(DEBOUNCE_CYC).
  - Burst counter: $clog2(BEEP_CYC).
  - Tone counter: $clog2(TONE_HALF_BASE*NUM_KEYS).
  - Counters never wrap; they clear on their terminal compare.
- Reset asserted mid-tone: outputs return to reset values on the next edge. A key held through reset is re-debounced and produces a fresh `key_flag`.

## Structure
- Shared package `beep_pkg`:
  - Mode encoding (`MODE_ONESHOT`=0, `MODE_TOGGLE`=1).
  - FSM state enum.
  - Default timing constants (`CLK_FREQ_HZ`, millisecond-to-cycle conversion).
- One sub-module: `key_debounce_ch`, a single-channel synchroniser, debounce counter and press flag. It is instantiated NUM_KEYS times via generate.
- Priority select, FSM and tone/burst counters stay in the top.

## Test plan
Parameters: NUM_KEYS=4, DEBOUNCE_CYC=8, BEEP_CYC=100, TONE_HALF_BASE=4.
- Clean press of key 1 held 20 cycles, mode=0 → one `key_flag[1]` pulse 10 cycles after the edge; `busy` high for exactly 100 cycles; `beep` period 16 cycles; no flag on release.
- Key 0 bounces 0/1 every 3 cycles for 30 cycles, then holds 0 → no flag during bounce; a single flag 10 cycles after the last transition.
- Keys 2 and 3 pressed in the same cycle → only key 2 is accepted; `active_key`=2; `beep` period 24 cycles.
- mode=1: press key 0, wait 300 cycles, press key 0 again → `busy` stays high throughout the 300 cycles; `busy` falls and `beep`=0 one cycle after the second `key_flag`.
- ONESHOT on key 0, then key 3 pressed at burst cycle 50 → switch to `active_key`=3, counters restart, `busy` held high 100 cycles from the second flag.
- `sys_rst` pulsed at burst cycle 40 while key 1 is held → all outputs return to reset values; a fresh `key_flag[1]` occurs 10 cycles after reset release.
